// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution datapath.
//   KERNEL_SIZE    : window edge length
//   DEF_DATA_WIDTH : default pixel width
//   window_t       : [row][col] window shape at the default pixel width
//   cnt_w()        : counter width for a dimension of n positions
//   win_bits()     : flattened bit count of a window for a given pixel width
package conv_pkg;
  localparam int KERNEL_SIZE    = 3;
  localparam int DEF_DATA_WIDTH = 4;

  typedef logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DEF_DATA_WIDTH-1:0] window_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int win_bits(input int dw);
    return KERNEL_SIZE * KERNEL_SIZE * dw;
  endfunction
endpackage

// File: rtl/conv3_line_buffer.sv
// One image row of delay: DEPTH-deep, DATA_WIDTH-wide shift register that
// advances only when i_en is high. o_data is the sample shifted in DEPTH
// enables ago. Storage is deliberately not reset; the window generator never
// looks at it before a full row has been written.
//   i_clk  : clock
//   i_en   : shift enable (pixel accept)
//   i_data : sample in
//   o_data : sample DEPTH enables old
module conv3_line_buffer #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

  always_ff @(posedge i_clk) begin
    if (i_en) mem_q <= {mem_q[DEPTH-2:0], i_data};
  end

  assign o_data = mem_q[DEPTH-1];
endmodule

// File: rtl/conv3_window_gen.sv
// 3x3 sliding-window generator: takes a raster pixel stream and emits every
// fully-interior 3x3 window ((IMG_H-2)*(IMG_W-2) per frame) through a single
// output register with valid/ready handshake at full throughput.
// Optional feature macro: WINDOW_COORD_EN adds o_win_row/o_win_col carrying
// the centre-pixel coordinate of o_window.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_valid/o_ready    : pixel handshake, i_pixel raster order
//   o_valid/i_ready    : window handshake
//   o_window           : [row][col], [2][2] newest pixel
//   o_last             : window of the frame's final pixel
module conv3_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_W      = 16,
  parameter int IMG_H      = 16,
  localparam int CW        = cnt_w(IMG_W),
  localparam int RW        = cnt_w(IMG_H)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_pixel,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] o_window,
  output logic                  o_last
`ifdef WINDOW_COORD_EN
  ,
  output logic [RW-1:0]         o_win_row,
  output logic [CW-1:0]         o_win_col
`endif
);
  typedef logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] win_t;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  win_t          arr_q, arr_d, win_q, win_d;
  logic          vld_q, vld_d, last_q, last_d;
  logic [DATA_WIDTH-1:0] lb0_out, lb1_out;
  logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0] new_col;
  logic          accept, emit, col_end, row_end;

  assign o_ready = ~vld_q | i_ready;
  assign accept  = i_valid & o_ready;
  assign col_end = (col_q == CW'(IMG_W-1));
  assign row_end = (row_q == RW'(IMG_H-1));
  // col>=2 also keeps windows from straddling a row wrap.
  assign emit    = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  // Cascaded: lb0 yields the pixel one row up, lb1 two rows up.
  conv3_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb0 (
    .i_clk(i_clk), .i_en(accept), .i_data(i_pixel), .o_data(lb0_out));
  conv3_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb1 (
    .i_clk(i_clk), .i_en(accept), .i_data(lb0_out), .o_data(lb1_out));

  assign new_col = {lb1_out, lb0_out, i_pixel};

  always_comb begin
    arr_d  = arr_q;
    col_d  = col_q;
    row_d  = row_q;
    vld_d  = vld_q;
    win_d  = win_q;
    last_d = last_q;
    if (accept) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE-1; c++) arr_d[r][c] = arr_q[r][c+1];
        arr_d[r][KERNEL_SIZE-1] = new_col[r];
      end
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    // A fresh window overrides a same-cycle consume of the old one.
    if (emit) begin
      vld_d  = 1'b1;
      win_d  = arr_d;
      last_d = row_end && col_end;
    end else if (vld_q && i_ready) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q  <= '0;
      row_q  <= '0;
      arr_q  <= '0;
      win_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      arr_q  <= arr_d;
      win_q  <= win_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign o_valid  = vld_q;
  assign o_window = win_q;
  assign o_last   = last_q;

`ifdef WINDOW_COORD_EN
  logic [RW-1:0] wrow_q;
  logic [CW-1:0] wcol_q;

  // Centre of the window is one row and one column behind the newest pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wrow_q <= '0;
      wcol_q <= '0;
    end else if (emit) begin
      wrow_q <= row_q - 1'b1;
      wcol_q <= col_q - 1'b1;
    end
  end

  assign o_win_row = wrow_q;
  assign o_win_col = wcol_q;
`endif
endmodule

// File: tb/tb_conv3_window_gen.sv
module tb_conv3_window_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] pixel = '0;
  logic       ready = 1'b0;
  logic       sel = 1'b0;   // 0: 4x4 instance, 1: 8x5 instance

  logic rdy4, v4, last4, rdy8, v8, last8;
  logic [0:2][0:2][3:0] win4, win8;
`ifdef WINDOW_COORD_EN
  logic [1:0] r4, c4;
  logic [2:0] r8, c8;
`endif

  always #5 clk = ~clk;

  conv3_window_gen #(.DATA_WIDTH(4), .IMG_W(4), .IMG_H(4)) u4 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy4), .i_pixel(pixel),
    .o_valid(v4), .i_ready(ready), .o_window(win4), .o_last(last4)
`ifdef WINDOW_COORD_EN
    , .o_win_row(r4), .o_win_col(c4)
`endif
  );

  conv3_window_gen #(.DATA_WIDTH(4), .IMG_W(8), .IMG_H(5)) u8 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy8), .i_pixel(pixel),
    .o_valid(v8), .i_ready(ready), .o_window(win8), .o_last(last8)
`ifdef WINDOW_COORD_EN
    , .o_win_row(r8), .o_win_col(c8)
`endif
  );

  typedef struct packed {
    logic [35:0] win;
    logic        last;
    logic [7:0]  r;
    logic [7:0]  c;
  } obs_t;

  obs_t rx[$];
  obs_t ex[$];
  int   stim[$];
  int   checks = 0;
  int   failures = 0;

  wire dut_rdy = sel ? rdy8 : rdy4;

  // Record every consumed window of the selected instance.
  always @(negedge clk) begin
    obs_t o;
    o = '0;
    if (!rst && ready) begin
      if (!sel && v4) begin
        o.win = win4; o.last = last4;
`ifdef WINDOW_COORD_EN
        o.r = 8'(r4); o.c = 8'(c4);
`endif
        rx.push_back(o);
      end else if (sel && v8) begin
        o.win = win8; o.last = last8;
`ifdef WINDOW_COORD_EN
        o.r = 8'(r8); o.c = 8'(c8);
`endif
        rx.push_back(o);
      end
    end
  end

  // Reference: every interior 3x3 neighbourhood of a W x H frame in stim.
  task automatic build_exp(input int w, input int h, input int base);
    for (int r = 2; r < h; r++)
      for (int c = 2; c < w; c++) begin
        obs_t o;
        logic [3:0] p;
        o = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            p = 4'(stim[base + (r-2+i)*w + (c-2+j)]);
            o.win = (o.win << 4) | 36'(p);
          end
        o.last = (r == h-1) && (c == w-1);
`ifdef WINDOW_COORD_EN
        o.r = 8'(r-1); o.c = 8'(c-1);
`endif
        ex.push_back(o);
      end
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rx.delete(); ex.delete(); stim.delete();
  endtask

  // Feed stim[start..] with random gaps until all pixels are in and exp_n
  // windows have been consumed.
  task automatic run_stream(input int start, input int pv, input int pr, input int exp_n);
    int i, cyc;
    i = start; cyc = 0;
    while ((i < stim.size() || rx.size() < exp_n) && cyc < 4000) begin
      valid = (i < stim.size()) && ($urandom_range(99) < pv);
      pixel = (i < stim.size()) ? 4'(stim[i]) : 4'h0;
      ready = ($urandom_range(99) < pr);
      @(negedge clk);
      if (valid && dut_rdy) i++;
      @(posedge clk); #1;
      cyc++;
    end
    valid = 1'b0; ready = 1'b0;
    checks++;
    if (cyc >= 4000) begin
      failures++;
      $display("FAIL stream_timeout accepted=%0d/%0d windows=%0d/%0d", i, stim.size(), rx.size(), exp_n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({v4, last4, rdy4} !== 3'b001 || win4 !== '0) begin
      failures++; $display("FAIL reset_4x4 valid/last/ready=%b%b%b win=%h want 001/0", v4, last4, rdy4, win4);
    end
    checks++;
    if ({v8, last8, rdy8} !== 3'b001 || win8 !== '0) begin
      failures++; $display("FAIL reset_8x5 valid/last/ready=%b%b%b win=%h want 001/0", v8, last8, rdy8, win8);
    end
`ifdef WINDOW_COORD_EN
    checks++;
    if (r4 !== 2'd0 || c4 !== 2'd0 || r8 !== 3'd0 || c8 !== 3'd0) begin
      failures++; $display("FAIL reset_coord got %0d,%0d %0d,%0d want zeros", r4, c4, r8, c8);
    end
`endif
  endtask

  task automatic test_basic();
    sel = 1'b0; do_reset();
    for (int k = 0; k < 16; k++) stim.push_back(k);
    build_exp(4, 4, 0);
    for (int k = 0; k < 16; k++) begin
      valid = 1'b1; pixel = 4'(k); ready = 1'b1;
      @(posedge clk); #1;
      if (k == 9) begin
        checks++;
        if (v4 !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b want 0", v4); end
      end
      if (k == 10) begin
        checks++;
        if (v4 !== 1'b1 || win4 !== 36'h01245689A) begin
          failures++; $display("FAIL basic_first_window valid=%b win=%h want 1/01245689a", v4, win4);
        end
      end
    end
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 ready = 1'b0;
    checks++;
    if (rx.size() != 4) begin failures++; $display("FAIL basic_count got=%0d want 4", rx.size()); end
    else begin
      checks++;
      if (rx[3].win !== 36'h5679ABDEF || rx[3].last !== 1'b1 || rx[2].last !== 1'b0) begin
        failures++; $display("FAIL basic_last_window win=%h last=%b want 5679abdef/1", rx[3].win, rx[3].last);
      end
    end
    for (int k = 0; k < ex.size() && k < rx.size(); k++) begin
      checks++;
      if (rx[k] !== ex[k]) begin failures++; $display("FAIL basic_win[%0d] got=%h want=%h", k, rx[k], ex[k]); end
    end
  endtask

  task automatic test_backpressure();
    int i, cyc;
    sel = 1'b0; do_reset();
    for (int k = 0; k < 16; k++) stim.push_back(k);
    build_exp(4, 4, 0);
    i = 0; cyc = 0; ready = 1'b1;
    while (v4 !== 1'b1 && cyc < 100) begin
      valid = 1'b1; pixel = 4'(stim[i]);
      @(negedge clk);
      if (rdy4) i++;
      @(posedge clk); #1;
      cyc++;
    end
    ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      valid = 1'b1; pixel = 4'(stim[i]);
      @(negedge clk);
      checks++;
      if (rdy4 !== 1'b0 || v4 !== 1'b1 || win4 !== ex[0].win) begin
        failures++; $display("FAIL stall[%0d] ready=%b valid=%b win=%h want 0/1/%h", s, rdy4, v4, win4, ex[0].win);
      end
      if (rdy4) i++;
      @(posedge clk); #1;
    end
    checks++;
    if (i != 11) begin failures++; $display("FAIL stall_accepted got=%0d want 11", i); end
    run_stream(i, 100, 100, 4);
    checks++;
    if (rx.size() != 4) begin failures++; $display("FAIL stall_count got=%0d want 4", rx.size()); end
    for (int k = 0; k < ex.size() && k < rx.size(); k++) begin
      checks++;
      if (rx[k] !== ex[k]) begin failures++; $display("FAIL stall_win[%0d] got=%h want=%h", k, rx[k], ex[k]); end
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; do_reset();
    for (int k = 0; k < 32; k++) stim.push_back(int'($urandom_range(15)));
    build_exp(4, 4, 0);
    build_exp(4, 4, 16);
    run_stream(0, 100, 100, 8);
    checks++;
    if (rx.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d want 8", rx.size()); end
    for (int k = 0; k < ex.size() && k < rx.size(); k++) begin
      checks++;
      if (rx[k] !== ex[k]) begin failures++; $display("FAIL b2b_win[%0d] got=%h want=%h", k, rx[k], ex[k]); end
    end
  endtask

  task automatic test_reset_midframe();
    sel = 1'b0; do_reset();
    for (int k = 0; k < 10; k++) stim.push_back(k + 3);
    run_stream(0, 100, 100, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++;
    if (v4 !== 1'b0 || last4 !== 1'b0 || win4 !== '0) begin
      failures++; $display("FAIL midreset_state valid=%b last=%b win=%h want 0/0/0", v4, last4, win4);
    end
    rx.delete(); ex.delete(); stim.delete();
    for (int k = 0; k < 16; k++) stim.push_back(k);
    build_exp(4, 4, 0);
    run_stream(0, 80, 80, 4);
    checks++;
    if (rx.size() != 4) begin failures++; $display("FAIL midreset_count got=%0d want 4", rx.size()); end
    else begin
      checks++;
      if (rx[0].win !== 36'h01245689A) begin failures++; $display("FAIL midreset_first got=%h want 01245689a", rx[0].win); end
    end
    for (int k = 0; k < ex.size() && k < rx.size(); k++) begin
      checks++;
      if (rx[k] !== ex[k]) begin failures++; $display("FAIL midreset_win[%0d] got=%h want=%h", k, rx[k], ex[k]); end
    end
  endtask

  task automatic test_random();
    sel = 1'b1; do_reset();
    for (int k = 0; k < 80; k++) stim.push_back(int'($urandom_range(15)));
    build_exp(8, 5, 0);
    build_exp(8, 5, 40);
    run_stream(0, 60, 55, 36);
    checks++;
    if (rx.size() != 36) begin failures++; $display("FAIL random_count got=%0d want 36", rx.size()); end
    for (int k = 0; k < ex.size() && k < rx.size(); k++) begin
      checks++;
      if (rx[k] !== ex[k]) begin failures++; $display("FAIL random_win[%0d] got=%h want=%h", k, rx[k], ex[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
